// File: rtl/snn_soc_pkg.sv
// Shared SNN core types: sequencer state encoding (exported for status readback)
// and WL pad group sizing.
package snn_soc_pkg;

  localparam int unsigned WL_GROUP_COUNT = 8;
  localparam int unsigned WL_GROUP_SEL_W = $clog2(WL_GROUP_COUNT);

  typedef enum logic [3:0] {
    StIdle    = 4'd0,
    StClear   = 4'd1,
    StFetch   = 4'd2,
    StWlSend  = 4'd3,
    StDacWait = 4'd4,
    StCimRun  = 4'd5,
    StAdcRun  = 4'd6,
    StLifAcc  = 4'd7,
    StDone    = 4'd8
  } seq_state_t;

endpackage

// File: rtl/snn_wl_serializer.sv
// Splits a captured bit-plane into WL_GROUP_COUNT pad cycles, group 0 first,
// with registered data/select/latch and a last-group flag for the sequencer.
module snn_wl_serializer
  import snn_soc_pkg::*;
#(
  parameter int unsigned NUM_INPUTS     = 64,
  parameter int unsigned WL_GROUP_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic                      go,
  input  logic [NUM_INPUTS-1:0]     plane,
  output logic [WL_GROUP_WIDTH-1:0] wl_data,
  output logic [WL_GROUP_SEL_W-1:0] wl_group_sel,
  output logic                      wl_latch,
  output logic                      last
);

  logic [WL_GROUP_WIDTH-1:0] groups [WL_GROUP_COUNT];
  logic [WL_GROUP_SEL_W-1:0] grp_next;

  for (genvar g = 0; g < WL_GROUP_COUNT; g++) begin : g_split
    assign groups[g] = plane[g*WL_GROUP_WIDTH +: WL_GROUP_WIDTH];
  end

  assign grp_next = wl_group_sel + WL_GROUP_SEL_W'(1);
  assign last     = wl_latch && (wl_group_sel == WL_GROUP_SEL_W'(WL_GROUP_COUNT - 1));

  // wl_latch doubles as the "sending" flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wl_data      <= '0;
      wl_group_sel <= '0;
      wl_latch     <= 1'b0;
    end else if (clr) begin
      wl_data      <= '0;
      wl_group_sel <= '0;
      wl_latch     <= 1'b0;
    end else if (go) begin
      wl_data      <= groups[0];
      wl_group_sel <= '0;
      wl_latch     <= 1'b1;
    end else if (wl_latch) begin
      if (last) begin
        wl_data      <= '0;
        wl_group_sel <= '0;
        wl_latch     <= 1'b0;
      end else begin
        wl_data      <= groups[grp_next];
        wl_group_sel <= grp_next;
      end
    end
  end

endmodule

// File: rtl/snn_infer_seq.sv
// Bit-plane inference sequencer: FIFO pop -> WL pads -> DAC settle -> CIM -> ADC -> LIF.
// Optional CIM/ADC watchdog enabled by defining SNN_SEQ_TIMEOUT_EN.
module snn_infer_seq
  import snn_soc_pkg::*;
#(
  parameter int unsigned NUM_INPUTS         = 64,
  parameter int unsigned WL_GROUP_WIDTH     = 8,
  parameter int unsigned PIXEL_BITS         = 8,
  parameter int unsigned DAC_LATENCY_CYCLES = 5,
  parameter int unsigned TIMEOUT_CYCLES     = 4096
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic [7:0]                timesteps,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  input  logic                      fifo_empty,
  input  logic [NUM_INPUTS-1:0]     fifo_rdata,
  output logic                      fifo_rd_en,
  output logic [WL_GROUP_WIDTH-1:0] wl_data,
  output logic [WL_GROUP_SEL_W-1:0] wl_group_sel,
  output logic                      wl_latch,
  output logic                      cim_start,
  input  logic                      cim_done,
  output logic                      adc_start,
  input  logic                      adc_done,
  output logic                      lif_clear,
  output logic                      lif_acc,
  output logic [2:0]                lif_shift
);

  localparam int unsigned DacW = (DAC_LATENCY_CYCLES > 1) ? $clog2(DAC_LATENCY_CYCLES) : 1;

  seq_state_t            state_q;
  logic [NUM_INPUTS-1:0] plane_q;
  logic [2:0]            plane_idx_q;
  logic [7:0]            ts_idx_q;
  logic [7:0]            ts_tot_q;
  logic [DacW-1:0]       dac_cnt_q;
  logic                  wl_go;
  logic                  wl_last;
  logic                  plane_wrap;

  assign wl_go      = (state_q == StFetch) && fifo_rd_en;
  assign plane_wrap = (plane_idx_q == 3'(PIXEL_BITS - 1));

`ifdef SNN_SEQ_TIMEOUT_EN
  logic [15:0] wd_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^32'(TIMEOUT_CYCLES);
  assign err        = 1'b0;
`endif

  // The pop is registered, so it is decided one cycle ahead on entry to FETCH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      plane_q     <= '0;
      plane_idx_q <= '0;
      ts_idx_q    <= '0;
      ts_tot_q    <= '0;
      dac_cnt_q   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      fifo_rd_en  <= 1'b0;
      cim_start   <= 1'b0;
      adc_start   <= 1'b0;
      lif_clear   <= 1'b0;
      lif_acc     <= 1'b0;
      lif_shift   <= '0;
`ifdef SNN_SEQ_TIMEOUT_EN
      wd_q        <= '0;
      err         <= 1'b0;
`endif
    end else begin
      done       <= 1'b0;
      fifo_rd_en <= 1'b0;
      cim_start  <= 1'b0;
      adc_start  <= 1'b0;
      lif_clear  <= 1'b0;
      lif_acc    <= 1'b0;
      if (abort && (state_q != StIdle)) begin
        state_q   <= StIdle;
        busy      <= 1'b0;
        lif_shift <= '0;
      end else begin
        case (state_q)
          StIdle: begin
            if (start) begin
              state_q     <= StClear;
              busy        <= 1'b1;
              lif_clear   <= 1'b1;
              ts_tot_q    <= (timesteps == 8'd0) ? 8'd1 : timesteps;
              plane_idx_q <= '0;
              ts_idx_q    <= '0;
`ifdef SNN_SEQ_TIMEOUT_EN
              err         <= 1'b0;
`endif
            end
          end
          StClear: begin
            state_q <= StFetch;
            if (!fifo_empty) begin
              fifo_rd_en <= 1'b1;
              plane_q    <= fifo_rdata;
            end
          end
          StFetch: begin
            if (fifo_rd_en) begin
              state_q <= StWlSend;
            end else if (!fifo_empty) begin
              fifo_rd_en <= 1'b1;
              plane_q    <= fifo_rdata;
            end
          end
          StWlSend: begin
            if (wl_last) begin
              state_q   <= StDacWait;
              dac_cnt_q <= '0;
            end
          end
          StDacWait: begin
            if (dac_cnt_q == DacW'(DAC_LATENCY_CYCLES - 1)) begin
              state_q   <= StCimRun;
              cim_start <= 1'b1;
`ifdef SNN_SEQ_TIMEOUT_EN
              wd_q      <= '0;
`endif
            end else begin
              dac_cnt_q <= dac_cnt_q + DacW'(1);
            end
          end
          StCimRun: begin
            if (cim_done) begin
              state_q   <= StAdcRun;
              adc_start <= 1'b1;
`ifdef SNN_SEQ_TIMEOUT_EN
              wd_q      <= '0;
            end else if (wd_q == 16'(TIMEOUT_CYCLES - 1)) begin
              state_q <= StIdle;
              busy    <= 1'b0;
              done    <= 1'b1;
              err     <= 1'b1;
            end else begin
              wd_q <= wd_q + 16'd1;
`endif
            end
          end
          StAdcRun: begin
            if (adc_done) begin
              state_q   <= StLifAcc;
              lif_acc   <= 1'b1;
              lif_shift <= 3'(PIXEL_BITS - 1) - plane_idx_q;
`ifdef SNN_SEQ_TIMEOUT_EN
            end else if (wd_q == 16'(TIMEOUT_CYCLES - 1)) begin
              state_q <= StIdle;
              busy    <= 1'b0;
              done    <= 1'b1;
              err     <= 1'b1;
            end else begin
              wd_q <= wd_q + 16'd1;
`endif
            end
          end
          StLifAcc: begin
            plane_idx_q <= plane_wrap ? 3'd0 : plane_idx_q + 3'd1;
            if (plane_wrap) begin
              ts_idx_q <= ts_idx_q + 8'd1;
            end
            if (plane_wrap && ((ts_idx_q + 8'd1) == ts_tot_q)) begin
              state_q <= StDone;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              state_q <= StFetch;
              if (!fifo_empty) begin
                fifo_rd_en <= 1'b1;
                plane_q    <= fifo_rdata;
              end
            end
          end
          StDone:  state_q <= StIdle;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  snn_wl_serializer #(
    .NUM_INPUTS     (NUM_INPUTS),
    .WL_GROUP_WIDTH (WL_GROUP_WIDTH)
  ) u_wl_serializer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (abort && (state_q != StIdle)),
    .go           (wl_go),
    .plane        (plane_q),
    .wl_data      (wl_data),
    .wl_group_sel (wl_group_sel),
    .wl_latch     (wl_latch),
    .last         (wl_last)
  );

endmodule
